memory_address_unit: RTL and testbench
======================================

# memory_address_unit

Parametrised successor of the memory address register. It holds the RAM address for the CPU and loads it from the bus, or from the front-panel switches in manual mode. It adds an auto-increment path for sequential RAM access, with a wrap pulse. The manual read button and switches are synchronised internally, and the button can optionally be debounced. The block sits between the bus and the RAM address input, alongside the control unit.

## Interface
Parameters:
- ADDR_W, default 4: address width. Must satisfy ADDR_W ≤ BUS_W.
- BUS_W, default 8: bus width.
- DEBOUNCE_CYCLES, default 16: consecutive stable-high cycles needed to accept a button press. Must be ≥ 1. Used only with the debounce feature.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- read_from_bus  input  1  load address from bus (auto mode).
- increment  input  1  address <= address + 1 (auto mode).
- manual_mode  input  1  1 = front-panel control; bus and increment ignored.
- manual_read  input  1  raw front-panel button, asynchronous.
- manual_switches  input  ADDR_W  raw front-panel address switches, asynchronous.
- bus  input  BUS_W  shared CPU bus.
- address  output  ADDR_W  registered RAM address.
- wrapped  output  1  one-cycle pulse: increment took address from all-ones to 0.
- manual_loaded  output  1  one-cycle pulse, concurrent with a manual address load.

## Operation
Reset values:
- address = 0, wrapped = 0, manual_loaded = 0.
- Synchroniser flops = 0, button FSM = IDLE, debounce counter = 0.

Per-edge priority, highest first:
- Manual load pulse while manual_mode = 1: address <= synchronised switches; manual_loaded = 1.
- read_from_bus while manual_mode = 0: address <= bus[ADDR_W-1:0]. Upper bus bits are ignored.
- increment while manual_mode = 0: address <= address + 1, modulo 2^ADDR_W. wrapped = 1 only when the old address is all-ones.
- Otherwise: hold.

Simultaneous requests:
- read_from_bus and increment together: the bus load wins and wrapped = 0.
- manual_mode = 1 with no load pulse: address holds, even if read_from_bus or increment is asserted.

Manual path:
- manual_read and manual_switches each pass through a 2-FF synchroniser.
- The synchronised button drives the button FSM, with states IDLE, COUNT, HELD.
- IDLE: button high → COUNT with counter = 1. If DEBOUNCE_CYCLES = 1, go directly to HELD and emit the pulse.
- COUNT: button low → IDLE, counter cleared. Counter reaching DEBOUNCE_CYCLES → HELD and emit the load pulse.
- HELD: button low → IDLE. No further pulse while held.
- The FSM runs regardless of manual_mode. A pulse arriving while manual_mode = 0 is discarded.
- A button held across reset deassertion counts as a fresh press and produces one load.

## Timing
- Bus load and increment: address updates on the same edge that samples the request. Latency is 1 cycle.
- wrapped and manual_loaded: registered outputs, asserted in the cycle after the causing edge, for exactly one cycle.
- Manual load, without debounce: button first sampled high at edge 1 → address updated at edge 3.
- Manual load, with debounce: button first sampled high at edge 1 → address updated at edge 2 + DEBOUNCE_CYCLES.
- Switches share the same synchroniser depth as the button, so the loaded value is the switch state at edge (load edge − 2).
- Button glitch shorter than DEBOUNCE_CYCLES: FSM returns to IDLE with no load.
- rst asserted mid-count: the FSM and all outputs clear immediately, asynchronously.

## Configuration
- MAR_DEBOUNCE_EN defined: the COUNT state and a counter of width $clog2(DEBOUNCE_CYCLES+1) are built, as described above.
- MAR_DEBOUNCE_EN undefined: no counter is built. IDLE goes directly to HELD on the synchronised rising edge and emits the pulse there. Behaviour equals DEBOUNCE_CYCLES = 1, and DEBOUNCE_CYCLES is ignored.

## Structure
- Shared package mar_pkg holds:
  - typedef enum logic [1:0] btn_state_e {IDLE, COUNT, HELD};
  - constant SYNC_STAGES = 2.
- Sub-module button_conditioner contains the button synchroniser, the FSM and the debounce counter, and outputs a one-cycle press pulse.
- The switch synchroniser and the address datapath stay in the top module.

## Test plan
- Reset, then bus = 8'hA7 with read_from_bus pulsed (ADDR_W = 4) → address = 4'h7 next cycle, no pulses.
- address = 4'hE with increment held 3 cycles → address 4'hF, then 4'h0 with wrapped = 1 for one cycle, then 4'h1.
- read_from_bus and increment together with bus = 8'h03 → address = 3, wrapped = 0.
- manual_mode = 1, switches = 4'h9, button held (DEBOUNCE_CYCLES = 4, MAR_DEBOUNCE_EN defined) → address = 9 at edge 6, manual_loaded pulses once; read_from_bus is ignored throughout.
- Button high for 2 cycles then low, with DEBOUNCE_CYCLES = 4 → no load, FSM returns to IDLE. Repeat without MAR_DEBOUNCE_EN → load at edge 3.
- rst asserted during COUNT → address = 0 immediately. Button held through release → exactly one load after release.

Source files
------------

// File: rtl/mar_pkg.sv
// Shared types and constants for the memory address unit and its button conditioner.
package mar_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, HELD} btn_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/button_conditioner.sv
// Front-panel button synchroniser plus press FSM; emits a one-cycle press pulse.
// The COUNT/debounce counter path exists only when MAR_DEBOUNCE_EN is defined.
//
// state | meaning
// IDLE  | button released, waiting for a synchronised high
// COUNT | button high, counting stable cycles toward DEBOUNCE_CYCLES
// HELD  | press accepted, waiting for release before re-arming
module button_conditioner
  import mar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn;
  btn_state_e             state_q, state_d;

`ifdef MAR_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign btn = sync_q[SYNC_STAGES-1];

  // press is Mealy so the load lands on the same edge the FSM accepts the press.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
    state_d = state_q;
    press   = 1'b0;
`ifdef MAR_DEBOUNCE_EN
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            press   = 1'b1;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      COUNT: begin
        if (!btn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`else
    case (state_q)
      IDLE: begin
        if (btn) begin
          state_d = HELD;
          press   = 1'b1;
        end
      end
      HELD: begin
        if (!btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
`ifdef MAR_DEBOUNCE_EN
      cnt_q   <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
`ifdef MAR_DEBOUNCE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: rtl/memory_address_unit.sv
// RAM address register: bus load, auto-increment with wrap pulse, and manual front-panel load.
// Optional button debounce is selected with MAR_DEBOUNCE_EN (see button_conditioner).
module memory_address_unit
  import mar_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter int BUS_W           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_from_bus,
  input  logic              increment,
  input  logic              manual_mode,
  input  logic              manual_read,
  input  logic [ADDR_W-1:0] manual_switches,
  input  logic [BUS_W-1:0]  bus,
  output logic [ADDR_W-1:0] address,
  output logic              wrapped,
  output logic              manual_loaded
);

  if (ADDR_W > BUS_W) begin : g_bad_cfg
    $error("ADDR_W must not exceed BUS_W");
  end

  logic [ADDR_W-1:0] sw_sync_q [SYNC_STAGES];
  logic [ADDR_W-1:0] sw_sync_d [SYNC_STAGES];
  logic [ADDR_W-1:0] address_q, address_d;
  logic              wrapped_q, wrapped_d;
  logic              manual_loaded_q, manual_loaded_d;
  logic              press;
  logic              unused_bus;

  // Only the low ADDR_W bus bits address RAM.
  assign unused_bus = ^bus;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(manual_read),
    .press  (press)
  );

  always_comb begin
    sw_sync_d[0] = manual_switches;
    for (int i = 1; i < SYNC_STAGES; i++) sw_sync_d[i] = sw_sync_q[i-1];
  end

  // Manual mode owns the register outright; bus load beats increment.
  always_comb begin
    address_d       = address_q;
    wrapped_d       = 1'b0;
    manual_loaded_d = 1'b0;
    if (manual_mode) begin
      if (press) begin
        address_d       = sw_sync_q[SYNC_STAGES-1];
        manual_loaded_d = 1'b1;
      end
    end else if (read_from_bus) begin
      address_d = bus[ADDR_W-1:0];
    end else if (increment) begin
      address_d = address_q + 1'b1;
      wrapped_d = &address_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      address_q       <= '0;
      wrapped_q       <= 1'b0;
      manual_loaded_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_d[i];
      address_q       <= address_d;
      wrapped_q       <= wrapped_d;
      manual_loaded_q <= manual_loaded_d;
    end
  end

  assign address       = address_q;
  assign wrapped       = wrapped_q;
  assign manual_loaded = manual_loaded_q;

endmodule

// File: tb/tb_memory_address_unit.sv
// Self-checking bench for memory_address_unit: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_memory_address_unit;

  localparam int ADDR_W = 4;
  localparam int BUS_W  = 8;
  localparam int DB     = 4;
`ifdef MAR_DEBOUNCE_EN
  localparam int N_EFF = DB;
`else
  localparam int N_EFF = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              read_from_bus, increment, manual_mode, manual_read;
  logic [ADDR_W-1:0] manual_switches;
  logic [BUS_W-1:0]  bus;
  logic [ADDR_W-1:0] address;
  logic              wrapped, manual_loaded;

  int checks = 0;
  int errors = 0;

  memory_address_unit #(
    .ADDR_W(ADDR_W), .BUS_W(BUS_W), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk            (clk),
    .rst            (rst_n),
    .read_from_bus  (read_from_bus),
    .increment      (increment),
    .manual_mode    (manual_mode),
    .manual_read    (manual_read),
    .manual_switches(manual_switches),
    .bus            (bus),
    .address        (address),
    .wrapped        (wrapped),
    .manual_loaded  (manual_loaded)
  );

  always #5 clk = ~clk;

  // Reference model: a press is accepted when the button, seen two edges late,
  // has been high for exactly N_EFF consecutive edges.
  logic [ADDR_W-1:0] m_addr;
  logic              m_wrap, m_ml;
  logic              btn_hist [2];
  logic [ADDR_W-1:0] sw_hist  [2];
  int                run;
  logic              m_press;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr = '0; m_wrap = 1'b0; m_ml = 1'b0; run = 0;
      btn_hist[0] = 1'b0; btn_hist[1] = 1'b0;
      sw_hist[0]  = '0;   sw_hist[1]  = '0;
    end else begin
      run     = btn_hist[1] ? ((run < 1000) ? run + 1 : run) : 0;
      m_press = btn_hist[1] && (run == N_EFF);
      m_wrap  = 1'b0;
      m_ml    = 1'b0;
      if (manual_mode) begin
        if (m_press) begin
          m_addr = sw_hist[1];
          m_ml   = 1'b1;
        end
      end else if (read_from_bus) begin
        m_addr = bus[ADDR_W-1:0];
      end else if (increment) begin
        m_wrap = (m_addr == {ADDR_W{1'b1}});
        m_addr = m_addr + 1'b1;
      end
      btn_hist[1] = btn_hist[0]; btn_hist[0] = manual_read;
      sw_hist[1]  = sw_hist[0];  sw_hist[0]  = manual_switches;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_address", 32'(address), 32'(m_addr));
    chk("model_wrapped", 32'(wrapped), 32'(m_wrap));
    chk("model_manual_loaded", 32'(manual_loaded), 32'(m_ml));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  int loaded_edge, pulses;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; read_from_bus = 0; increment = 0; manual_mode = 0;
    manual_read = 0; manual_switches = '0; bus = '0;
    repeat (3) step();
    chk("reset_address", 32'(address), 32'h0);
    chk("reset_pulses", 32'({wrapped, manual_loaded}), 32'h0);
    rst_n = 1'b1;
    step();

    // bus load ignores upper bits
    bus = 8'hA7; read_from_bus = 1;
    step();
    read_from_bus = 0; bus = 8'h00;
    chk("bus_load", 32'(address), 32'h7);
    chk("bus_load_no_pulse", 32'({wrapped, manual_loaded}), 32'h0);

    // increment through wrap
    bus = 8'h0E; read_from_bus = 1;
    step();
    read_from_bus = 0; increment = 1;
    step();
    chk("inc_to_f", 32'(address), 32'hF);
    chk("inc_to_f_wrap", 32'(wrapped), 32'h0);
    step();
    chk("inc_wrap_addr", 32'(address), 32'h0);
    chk("inc_wrap_pulse", 32'(wrapped), 32'h1);
    step();
    increment = 0;
    chk("inc_after_wrap", 32'(address), 32'h1);
    chk("inc_after_wrap_pulse", 32'(wrapped), 32'h0);

    // bus beats increment, even from all-ones
    bus = 8'h0F; read_from_bus = 1;
    step();
    bus = 8'h03; increment = 1;
    step();
    read_from_bus = 0; increment = 0;
    chk("bus_vs_inc_addr", 32'(address), 32'h3);
    chk("bus_vs_inc_wrap", 32'(wrapped), 32'h0);

    // manual load with bus request ignored
    manual_mode = 1; manual_switches = 4'h9; read_from_bus = 1; increment = 1;
    bus = 8'h55; manual_read = 1;
    loaded_edge = 0; pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (address == 4'h9 && loaded_edge == 0) loaded_edge = e;
      if (manual_loaded) pulses++;
    end
    chk("manual_load_edge", 32'(loaded_edge), 32'(2 + N_EFF));
    chk("manual_load_pulses", 32'(pulses), 32'h1);
    manual_read = 0; read_from_bus = 0; increment = 0;
    repeat (4) step();

    // short glitch: rejected with debounce, accepted without
    manual_switches = 4'h5; manual_read = 1;
    step(); step();
    manual_read = 0;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (manual_loaded) pulses++;
    end
    chk("glitch_pulses", 32'(pulses), 32'((N_EFF > 2) ? 1'b0 : 1'b1));
    chk("glitch_address", 32'(address), (N_EFF > 2) ? 32'h9 : 32'h5);

    // reset mid-count, button held through release
    manual_switches = 4'hC; manual_read = 1;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("async_reset_address", 32'(address), 32'h0);
    chk("async_reset_pulses", 32'({wrapped, manual_loaded}), 32'h0);
    step(); step();
    rst_n = 1'b1;
    pulses = 0;
    for (int e = 0; e < 15; e++) begin
      step();
      if (manual_loaded) pulses++;
    end
    chk("post_reset_pulses", 32'(pulses), 32'h1);
    chk("post_reset_address", 32'(address), 32'hC);
    manual_read = 0; manual_mode = 0;
    repeat (3) step();

    // randomized traffic; model checked every cycle
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) manual_mode = ~manual_mode;
      if ($urandom_range(5) == 0) manual_read = ~manual_read;
      manual_switches = ADDR_W'($urandom);
      bus             = BUS_W'($urandom);
      read_from_bus   = ($urandom_range(3) == 0);
      increment       = ($urandom_range(1) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
